ex_flag_stage: RTL and testbench
================================

// Module: ex_flag_stage
// PURPOSE
//   Stage directly downstream of the 16-bit saturating add/sub (CLA) unit.
//   Registers the ALU result into the EX/MEM boundary and maintains the Z/N/V flag register.
//   Evaluates the 3-bit branch condition against the registered flags.
//   Sits between the EX-stage ALU mux and the MEM stage; feeds the branch unit.
// PARAMETERS
//   WIDTH  16  data width of ALU result
//   OPW    4   opcode width
// PORTS
//   clk         in   1      system clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   ex_valid    in   1      EX holds a valid instruction this cycle
//   ex_op       in   OPW    opcode of the EX instruction
//   ex_sum      in   WIDTH  ALU result (already saturated by add/sub unit)
//   ex_ovfl     in   1      add/sub saturation/overflow indication
//   stall       in   1      hold all state this cycle
//   flush       in   1      squash the EX instruction
//   mem_valid   out  1      registered valid into MEM
//   mem_result  out  WIDTH  registered ALU result
//   flag_z      out  1      zero flag
//   flag_n      out  1      negative flag
//   flag_v      out  1      overflow flag
//   br_cond     in   3      branch condition code
//   br_taken    out  1      condition true against registered flags (combinational)
// BEHAVIOUR
//   Reset (async, rst_n=0): mem_valid=0, mem_result=0, flag_z=flag_n=flag_v=0. br_taken follows flags.
//   Opcodes: ADD=0000 SUB=0001 XOR=0010 RED=0011 SLL=0100 SRA=0101 ROR=0110 PADDSB=0111; others non-ALU.
//   Per rising edge, priority flush > stall > normal:
//    - flush=1: mem_valid<=0; mem_result held; flags held (flush wins over stall).
//    - stall=1, flush=0: every register holds.
//    - else: mem_valid<=ex_valid; if ex_valid then mem_result<=ex_sum.
//   Flag update only when ex_valid & ~stall & ~flush:
//    - ADD/SUB: Z<=(ex_sum==0); N<=ex_sum[15]; V<=ex_ovfl.
//    - XOR/SLL/SRA/ROR: Z<=(ex_sum==0); N and V held.
//    - RED, PADDSB, all other ops: no flag change.
//   Z, N, V are computed from the saturated ex_sum.
//    - Saturated positive 0x7FFF: N=0, Z=0, V=1.
//    - Saturated negative 0x8000: N=1, Z=0, V=1.
//   Latency: result and flags are visible 1 cycle after capture.
//    - A branch in the cycle after a flag-setter sees the new flags; no bypass from ex_* to br_taken.
//   br_cond decode (combinational, registered flags only):
//    - 000 NE: ~Z          001 EQ: Z
//    - 010 GT: ~Z & ~N     011 LT: N
//    - 100 GE: Z | (~Z & ~N)  101 LE: N | Z
//    - 110 OV: V           111 UN: 1
//   ex_valid=0 with no stall/flush: mem_valid<=0; mem_result and flags hold.
//   Reset asserted mid-operation: all registers clear immediately, regardless of clk/stall/flush.
// STRUCTURE
//   Shared package wisc_pkg holds the opcode and branch-condition constants.
//   Sub-module br_cond_eval holds the purely combinational cond/flags -> taken decode.
//   Pipeline/flag registers live in this module.
// TESTING
//   Reset: rst_n=0 mid-cycle -> outputs 0 at once; br_cond=000 -> br_taken=1, br_cond=001 -> 0.
//   ADD: ex_op=0000, ex_sum=30000, ex_ovfl=0 -> next cycle mem_result=30000, Z=0 N=0 V=0.
//   Saturation: ADD ex_sum=0x7FFF, ex_ovfl=1 -> V=1 N=0; br_cond=110 -> br_taken=1.
//   SUB=0: ex_op=0001, ex_sum=0 -> Z=1 N=0 V=0; br_cond=100 -> 1, br_cond=010 -> 0.
//   XOR after negative SUB (0x8000, ovfl=1): XOR ex_sum=0 -> Z=1, N=1 and V=1 retained.
//   Stall/flush: stall=1 with ADD 0 -> flags/mem_result unchanged.
//    stall=1 and flush=1 -> mem_valid=0, flags unchanged.
//    RED ex_sum=0 -> Z unchanged.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared opcode and branch-condition constants for the EX/MEM boundary logic.
// Also classifies which flags each opcode is allowed to write.
package wisc_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 4;

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_XOR    = 4'b0010,
    OP_RED    = 4'b0011,
    OP_SLL    = 4'b0100,
    OP_SRA    = 4'b0101,
    OP_ROR    = 4'b0110,
    OP_PADDSB = 4'b0111
  } op_e;

  typedef enum logic [2:0] {
    BR_NE = 3'b000,
    BR_EQ = 3'b001,
    BR_GT = 3'b010,
    BR_LT = 3'b011,
    BR_GE = 3'b100,
    BR_LE = 3'b101,
    BR_OV = 3'b110,
    BR_UN = 3'b111
  } br_cond_e;

  typedef enum logic [1:0] {
    FLAGS_NONE = 2'b00,
    FLAGS_Z    = 2'b01,
    FLAGS_ZNV  = 2'b10
  } flag_upd_e;

  // Arithmetic ops own all three flags; logic/shift ops only touch Z.
  function automatic flag_upd_e flag_update(input logic [3:0] op);
    flag_upd_e upd;
    case (op)
      OP_ADD, OP_SUB:                 upd = FLAGS_ZNV;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: upd = FLAGS_Z;
      default:                        upd = FLAGS_NONE;
    endcase
    return upd;
  endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch-condition decode against the registered Z/N/V flags.
// No bypass from the EX stage: only committed flags are looked at.
module br_cond_eval
  import wisc_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       flag_z,
  input  logic       flag_n,
  input  logic       flag_v,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (br_cond_e'(cond))
      BR_NE:   taken = ~flag_z;
      BR_EQ:   taken = flag_z;
      BR_GT:   taken = ~flag_z & ~flag_n;
      BR_LT:   taken = flag_n;
      BR_GE:   taken = flag_z | (~flag_z & ~flag_n);
      BR_LE:   taken = flag_n | flag_z;
      BR_OV:   taken = flag_v;
      BR_UN:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_flag_stage.sv
// EX/MEM pipeline register plus Z/N/V flag register fed by the saturating add/sub unit.
// Branch condition is evaluated combinationally from the registered flags.
module ex_flag_stage
  import wisc_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int OPW   = OP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [OPW-1:0]   ex_op,
  input  logic [WIDTH-1:0] ex_sum,
  input  logic             ex_ovfl,
  input  logic             stall,
  input  logic             flush,
  output logic             mem_valid,
  output logic [WIDTH-1:0] mem_result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  input  logic [2:0]       br_cond,
  output logic             br_taken
);

  logic             mem_valid_reg;
  logic [WIDTH-1:0] mem_result_reg;
  logic             flag_z_reg, flag_n_reg, flag_v_reg;
  logic             flag_z_next, flag_n_next, flag_v_next;
  logic             capture;

  assign capture = ex_valid & ~stall & ~flush;

  always_comb begin
    flag_z_next = flag_z_reg;
    flag_n_next = flag_n_reg;
    flag_v_next = flag_v_reg;
    if (capture) begin
      case (flag_update(ex_op))
        FLAGS_ZNV: begin
          flag_z_next = (ex_sum == '0);
          flag_n_next = ex_sum[WIDTH-1];
          flag_v_next = ex_ovfl;
        end
        FLAGS_Z: flag_z_next = (ex_sum == '0);
        default: ;
      endcase
    end
  end

  // Flush outranks stall: a squashed slot must not reach MEM even while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_reg  <= 1'b0;
      mem_result_reg <= '0;
      flag_z_reg     <= 1'b0;
      flag_n_reg     <= 1'b0;
      flag_v_reg     <= 1'b0;
    end else begin
      if (flush) begin
        mem_valid_reg <= 1'b0;
      end else if (!stall) begin
        mem_valid_reg <= ex_valid;
        if (ex_valid) mem_result_reg <= ex_sum;
      end
      flag_z_reg <= flag_z_next;
      flag_n_reg <= flag_n_next;
      flag_v_reg <= flag_v_next;
    end
  end

  assign mem_valid  = mem_valid_reg;
  assign mem_result = mem_result_reg;
  assign flag_z     = flag_z_reg;
  assign flag_n     = flag_n_reg;
  assign flag_v     = flag_v_reg;

  br_cond_eval u_br_cond_eval (
    .cond   (br_cond),
    .flag_z (flag_z_reg),
    .flag_n (flag_n_reg),
    .flag_v (flag_v_reg),
    .taken  (br_taken)
  );

endmodule

// File: tb/tb_ex_flag_stage.sv
// Scoreboard bench for ex_flag_stage: stimulus pushes expected post-edge state,
// a monitor pops and compares one entry after every rising edge.
module tb_ex_flag_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [15:0] ex_sum;
  logic        ex_ovfl;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic [15:0] mem_result;
  logic        flag_z, flag_n, flag_v;
  logic [2:0]  br_cond;
  logic        br_taken;

  ex_flag_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_op      (ex_op),
    .ex_sum     (ex_sum),
    .ex_ovfl    (ex_ovfl),
    .stall      (stall),
    .flush      (flush),
    .mem_valid  (mem_valid),
    .mem_result (mem_result),
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .flag_v     (flag_v),
    .br_cond    (br_cond),
    .br_taken   (br_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] r;
    logic        z;
    logic        n;
    logic        o;
    logic        t;
    int          id;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int txn = 0;

  // Reference state: what the EX/MEM boundary should hold after the next edge.
  logic        m_valid, m_z, m_n, m_v;
  logic [15:0] m_result;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Branch truth from the condition names: signed relation of the last compare to zero.
  function automatic logic cond_true(input logic [2:0] c, input logic z, input logic n, input logic v);
    logic zero_cmp, neg_cmp, pos_cmp;
    zero_cmp = z;
    neg_cmp  = n;
    pos_cmp  = !z && !n;
    case (c)
      3'd0: return !zero_cmp;
      3'd1: return zero_cmp;
      3'd2: return pos_cmp;
      3'd3: return neg_cmp;
      3'd4: return zero_cmp || pos_cmp;
      3'd5: return neg_cmp || zero_cmp;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit is_arith(input logic [3:0] op);
    return op == 4'd0 || op == 4'd1;
  endfunction

  function automatic bit is_zonly(input logic [3:0] op);
    return op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6;
  endfunction

  task automatic step(input logic v, input logic [3:0] op, input logic [15:0] sum,
                      input logic ov, input logic st, input logic fl, input logic [2:0] c);
    exp_t e;
    @(negedge clk);
    ex_valid = v; ex_op = op; ex_sum = sum; ex_ovfl = ov;
    stall = st; flush = fl; br_cond = c;
    if (fl) begin
      m_valid = 1'b0;
    end else if (!st) begin
      m_valid = v;
      if (v) begin
        m_result = sum;
        if (is_arith(op)) begin
          m_z = (sum == 16'd0);
          m_n = sum[15];
          m_v = ov;
        end else if (is_zonly(op)) begin
          m_z = (sum == 16'd0);
        end
      end
    end
    e.v = m_valid; e.r = m_result; e.z = m_z; e.n = m_n; e.o = m_v;
    e.t = cond_true(c, m_z, m_n, m_v);
    e.id = txn;
    txn++;
    q.push_back(e);
  endtask

  // Monitor: one scoreboard entry per rising edge while stimulus is active.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("mem_valid#%0d", e.id), {15'd0, mem_valid}, {15'd0, e.v});
        chk($sformatf("mem_result#%0d", e.id), mem_result, e.r);
        chk($sformatf("flag_z#%0d", e.id), {15'd0, flag_z}, {15'd0, e.z});
        chk($sformatf("flag_n#%0d", e.id), {15'd0, flag_n}, {15'd0, e.n});
        chk($sformatf("flag_v#%0d", e.id), {15'd0, flag_v}, {15'd0, e.o});
        chk($sformatf("br_taken#%0d", e.id), {15'd0, br_taken}, {15'd0, e.t});
        $display("txn %0d: valid=%0b result=%h z=%0b n=%0b v=%0b taken=%0b",
                 e.id, mem_valid, mem_result, flag_z, flag_n, flag_v, br_taken);
      end
    end
  end

  task automatic model_reset();
    m_valid = 1'b0; m_result = 16'd0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_op = 4'd0; ex_sum = 16'd0; ex_ovfl = 1'b0;
    stall = 1'b0; flush = 1'b0; br_cond = 3'd0;
  endtask

  initial begin
    logic [15:0] rs;
    int budget;
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    #12;
    chk("reset_valid", {15'd0, mem_valid}, 16'd0);
    chk("reset_result", mem_result, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed scenarios.
    step(1, 4'b0000, 16'd30000, 0, 0, 0, 3'b010);   // ADD positive
    step(1, 4'b0000, 16'h7FFF, 1, 0, 0, 3'b110);    // saturated positive
    step(1, 4'b0001, 16'h0000, 0, 0, 0, 3'b100);    // SUB to zero, GE
    step(0, 4'b0000, 16'h1234, 0, 0, 0, 3'b010);    // GT with Z set
    step(1, 4'b0001, 16'h8000, 1, 0, 0, 3'b011);    // saturated negative
    step(1, 4'b0010, 16'h0000, 0, 0, 0, 3'b101);    // XOR zero keeps N,V
    step(1, 4'b0000, 16'h0000, 0, 1, 0, 3'b001);    // stalled ADD 0
    step(1, 4'b0000, 16'h0005, 0, 1, 1, 3'b000);    // stall+flush
    step(1, 4'b0011, 16'h0000, 0, 0, 0, 3'b001);    // RED zero: Z unchanged
    step(1, 4'b0111, 16'h0000, 1, 0, 0, 3'b110);    // PADDSB: no flag change
    step(1, 4'b1010, 16'hFFFF, 1, 0, 0, 3'b111);    // non-ALU op
    step(1, 4'b0100, 16'h0040, 0, 0, 0, 3'b000);    // SLL nonzero clears Z

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_valid", {15'd0, mem_valid}, 16'd0);
    chk("async_result", mem_result, 16'd0);
    chk("async_flags", {13'd0, flag_z, flag_n, flag_v}, 16'd0);
    br_cond = 3'b000;
    #1;
    chk("async_br_ne", {15'd0, br_taken}, 16'd1);
    br_cond = 3'b001;
    #1;
    chk("async_br_eq", {15'd0, br_taken}, 16'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with boundary values mixed in.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0: rs = 16'h0000;
        1: rs = 16'h7FFF;
        2: rs = 16'h8000;
        default: rs = 16'($urandom);
      endcase
      step(($urandom_range(0, 9) < 8), 4'($urandom_range(0, 15)), rs,
           1'($urandom), ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 10),
           3'($urandom_range(0, 7)));
    end

    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
